// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the vertical-blanking update scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_CLIENTS    = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_FCNT_W         = 16;

  // 640x480 VGA frame: visible lines and vertical blanking lines
  localparam int VGA_ACTIVE_LINES = 480;
  localparam int VGA_BLANK_LINES  = 45;

endpackage

// File: rtl/lowest_bit_onehot.sv
// Isolates the lowest set bit of a vector as a one-hot word (zero in, zero out).
module lowest_bit_onehot #(
  parameter int NUM_CLIENTS = 3
) (
  input  logic [NUM_CLIENTS-1:0] i_vec,
  output logic [NUM_CLIENTS-1:0] o_onehot
);

  // x & -x keeps only the least significant one; bit 0 is the highest priority
  assign o_onehot = i_vec & (~i_vec + NUM_CLIENTS'(1));

endmodule

// File: rtl/vblank_scheduler.sv
// Grants the per-frame update slot to requesting clients, one at a time in
// priority order, during vertical blanking; flags overruns and hung clients.
module vblank_scheduler
  import vga_sched_pkg::*;
#(
  parameter int NUM_CLIENTS    = DEF_NUM_CLIENTS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FCNT_W         = DEF_FCNT_W
) (
  input  logic                   clck,
  input  logic                   reset,
  input  logic                   activeLine,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [NUM_CLIENTS-1:0] done,
  input  logic                   clear_err,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [NUM_CLIENTS-1:0] start,
  output logic                   frame_start,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic [FCNT_W-1:0]      frame_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t           r_state, w_state_next;
  logic                   r_act_q;
  logic [NUM_CLIENTS-1:0] r_pending, w_pending_next;
  logic [NUM_CLIENTS-1:0] r_grant, w_grant_next;
  logic [NUM_CLIENTS-1:0] r_start, w_start_next;
  logic                   r_frame_start, w_frame_start_next;
  logic                   r_overrun, w_overrun_next;
  logic                   r_timeout_err, w_timeout_err_next;
  logic [FCNT_W-1:0]      r_frame_count, w_frame_count_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;

  logic                   w_fall;
  logic                   w_accept;
  logic                   w_set_overrun;
  logic                   w_set_timeout;
  logic [NUM_CLIENTS-1:0] w_lowest;
  logic [NUM_CLIENTS-1:0] w_remaining;

  lowest_bit_onehot #(
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_lowest (
    .i_vec   (r_pending),
    .o_onehot(w_lowest)
  );

  assign w_fall      = ~activeLine & r_act_q;
  // r_grant is zero outside GRANT, so done from anyone else never matches
  assign w_accept    = |(done & r_grant);
  assign w_remaining = r_pending & ~(r_grant & {NUM_CLIENTS{w_accept}});

  always_comb begin
    w_state_next       = r_state;
    w_pending_next     = r_pending;
    w_grant_next       = r_grant;
    w_start_next       = '0;
    w_frame_start_next = 1'b0;
    w_frame_count_next = r_frame_count;
    w_cnt_next         = r_cnt;
    w_set_overrun      = 1'b0;
    w_set_timeout      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_pending_next     = req;
          w_frame_count_next = r_frame_count + FCNT_W'(1);
          w_frame_start_next = 1'b1;
          w_state_next       = SCAN;
        end
      end
      SCAN: begin
        if (activeLine) begin
          w_set_overrun  = |r_pending;
          w_pending_next = '0;
          w_state_next   = IDLE;
        end else if (r_pending == '0) begin
          w_state_next = IDLE;
        end else begin
          w_grant_next = w_lowest;
          w_start_next = w_lowest;
          w_cnt_next   = '0;
          w_state_next = GRANT;
        end
      end
      GRANT: begin
        // Blanking ended: a same-cycle done still counts before judging overrun
        if (activeLine) begin
          w_set_overrun  = |w_remaining;
          w_pending_next = '0;
          w_grant_next   = '0;
          w_state_next   = IDLE;
        end else if (w_accept || (r_cnt == CNT_LAST)) begin
          w_set_timeout  = ~w_accept;
          w_pending_next = r_pending & ~r_grant;
          w_grant_next   = '0;
          w_state_next   = SCAN;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_pending_next = '0;
        w_grant_next   = '0;
        w_state_next   = IDLE;
      end
    endcase

    w_overrun_next     = w_set_overrun | (r_overrun & ~clear_err);
    w_timeout_err_next = w_set_timeout | (r_timeout_err & ~clear_err);
  end

  always_ff @(posedge clck or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_act_q       <= 1'b0;
      r_pending     <= '0;
      r_grant       <= '0;
      r_start       <= '0;
      r_frame_start <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_next;
      r_act_q       <= activeLine;
      r_pending     <= w_pending_next;
      r_grant       <= w_grant_next;
      r_start       <= w_start_next;
      r_frame_start <= w_frame_start_next;
      r_overrun     <= w_overrun_next;
      r_timeout_err <= w_timeout_err_next;
      r_frame_count <= w_frame_count_next;
      r_cnt         <= w_cnt_next;
    end
  end

  assign grant       = r_grant;
  assign start       = r_start;
  assign frame_start = r_frame_start;
  assign busy        = (r_state != IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Self-checking bench: each frame's grant timeline is planned from the
// request snapshot and client done delays, then compared cycle by cycle.
module tb_vblank_scheduler;
  import vga_sched_pkg::*;

  localparam int NC = 3;
  localparam int TO = 16;
  localparam int FW = 8;
  localparam int KMAX = 128;

  logic          clck = 1'b0;
  logic          reset = 1'b0;
  logic          activeLine = 1'b0;
  logic          clear_err = 1'b0;
  logic [NC-1:0] req = '0;
  logic [NC-1:0] done = '0;
  logic [NC-1:0] grant, start;
  logic          frame_start, busy, overrun, timeout_err;
  logic [FW-1:0] frame_count;

  int            checks = 0;
  int            fails = 0;
  logic [FW-1:0] m_fc = '0;
  bit            m_ovr = 1'b0;
  bit            m_to = 1'b0;

  always #5 clck = ~clck;

  vblank_scheduler #(
    .NUM_CLIENTS   (NC),
    .TIMEOUT_CYCLES(TO),
    .FCNT_W        (FW)
  ) dut (
    .clck       (clck),
    .reset      (reset),
    .activeLine (activeLine),
    .req        (req),
    .done       (done),
    .clear_err  (clear_err),
    .grant      (grant),
    .start      (start),
    .frame_start(frame_start),
    .busy       (busy),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .frame_count(frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clck);
    @(negedge clck);
  endtask

  // d >= TO means the client never answers. b_in < 2 means blanking outlasts
  // all work; otherwise activeLine is sampled high again at posedge b_in.
  task automatic run_frame(input logic [2:0] rq, input int d0, input int d1, input int d2,
                           input int b_in, input logic [2:0] nmask, input bit rnd_noise,
                           input bit clr);
    int         d[3];
    int         r[3];
    bit         tmo[3];
    logic [2:0] eg[KMAX];
    logic [2:0] es[KMAX];
    bit         eb[KMAX];
    int         pos, bk, maxk;
    bit         ovr_f;
    logic [2:0] nz;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int k = 0; k < KMAX; k++) begin
      eg[k] = '0; es[k] = '0; eb[k] = 1'b0;
    end

    // visible lines: scheduler must be idle, errors optionally cleared
    activeLine = 1'b1; clear_err = clr; done = '0; req = 3'($urandom);
    tick();
    clear_err = 1'b0;
    if (clr) begin m_ovr = 1'b0; m_to = 1'b0; end
    check("vis_busy", busy, 0);
    check("vis_grant", grant, 0);
    check("vis_overrun", overrun, m_ovr);
    check("vis_timeout", timeout_err, m_to);
    tick();
    tick();

    // plan: serve requested clients lowest index first, one SCAN cycle between
    pos = 2;
    for (int i = 0; i < NC; i++) begin
      r[i] = -1;
      tmo[i] = (d[i] >= TO);
      if (rq[i]) begin
        r[i] = pos + (tmo[i] ? TO : d[i] + 1);
        for (int k = pos; k < r[i]; k++) eg[k] = 3'b001 << i;
        es[pos] = 3'b001 << i;
        pos = r[i] + 1;
      end
    end
    for (int k = 1; k < pos; k++) eb[k] = 1'b1;
    bk = (b_in < 2) ? pos + 1 : b_in;
    for (int i = 0; i < NC; i++)
      if (rq[i] && tmo[i] && r[i] == bk) bk++;
    ovr_f = 1'b0;
    for (int i = 0; i < NC; i++)
      if (rq[i] && !(r[i] < bk || (r[i] == bk && !tmo[i]))) ovr_f = 1'b1;
    for (int k = bk; k < KMAX; k++) begin
      eg[k] = '0; es[k] = '0; eb[k] = 1'b0;
    end
    maxk = (bk > pos) ? bk : pos;
    m_fc = m_fc + FW'(1);

    activeLine = 1'b0;
    req = rq;
    for (int k = 1; k <= maxk; k++) begin
      tick();
      if (k == 1) req = 3'($urandom);
      for (int i = 0; i < NC; i++)
        if (rq[i] && tmo[i] && r[i] <= k && r[i] < bk) m_to = 1'b1;
      if (k == bk && ovr_f) m_ovr = 1'b1;
      check($sformatf("grant@%0d", k), grant, eg[k]);
      check($sformatf("start@%0d", k), start, es[k]);
      check($sformatf("busy@%0d", k), busy, eb[k]);
      check($sformatf("frame_start@%0d", k), frame_start, (k == 1));
      check($sformatf("frame_count@%0d", k), frame_count, m_fc);
      check($sformatf("overrun@%0d", k), overrun, m_ovr);
      check($sformatf("timeout_err@%0d", k), timeout_err, m_to);
      activeLine = (k + 1 >= bk);
      done = '0;
      for (int i = 0; i < NC; i++)
        if (rq[i] && !tmo[i] && r[i] == k + 1) done[i] = 1'b1;
      nz = rnd_noise ? 3'($urandom) : nmask;
      done = done | (nz & ~eg[k]);
    end
    done = '0;
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clck);
    check("rst_grant", grant, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b1;
    tick();

    run_frame(3'b101, 5, 99, 5, 0, 3'b000, 1'b0, 1'b0);
    run_frame(3'b010, 99, 99, 99, 0, 3'b000, 1'b0, 1'b0);
    run_frame(3'b000, 99, 99, 99, 0, 3'b000, 1'b0, 1'b1);
    run_frame(3'b111, 99, 99, 99, 9, 3'b000, 1'b0, 1'b0);
    run_frame(3'b001, 6, 99, 99, 0, 3'b100, 1'b0, 1'b1);
    run_frame(3'b011, 15, 2, 99, 0, 3'b000, 1'b0, 1'b0);

    // reset pulled mid-GRANT must clear outputs without waiting for a clock
    activeLine = 1'b1; tick(); tick();
    activeLine = 1'b0; req = 3'b001;
    tick(); tick(); tick();
    check("pre_rst_grant", grant, 3'b001);
    reset = 1'b0;
    #1;
    check("async_grant", grant, 0);
    check("async_start", start, 0);
    check("async_busy", busy, 0);
    check("async_frame_count", frame_count, 0);
    m_fc = '0; m_ovr = 1'b0; m_to = 1'b0;
    @(negedge clck);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_grant", grant, 0);
      check("post_rst_busy", busy, 0);
    end

    for (int f = 0; f < 40; f++)
      run_frame(3'($urandom), int'($urandom_range(0, 19)), int'($urandom_range(0, 19)),
                int'($urandom_range(0, 19)),
                ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(2, VGA_BLANK_LINES)),
                3'b000, 1'b1, ($urandom_range(0, 3) == 0));

    guard = 0;
    while (m_fc != '0 && guard < 300) begin
      run_frame(3'b000, 99, 99, 99, 0, 3'b000, 1'b0, 1'b0);
      guard++;
    end
    check("frame_count_wrap", frame_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
